maze_controller: RTL
====================

Name: maze_controller

Overview:
- FSM that sequences the rat-in-maze location datapath through a depth-first search of a 16x16 grid.
- Holds the current location, drives the direction and load strobe into the datapath, and reads and marks the 1-bit maze memory.
- Pushes and pops move directions on an external direction stack to backtrack.
- Signals done when the goal cell is reached and fail when the search is exhausted.

Parameters:
- START_LOC, 8'h00, start cell {x,y}.
- GOAL_LOC, 8'hFF, goal cell {x,y}.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin search; sampled in IDLE, DONE and FAIL.
- currLoc  out  8  registered current location {x[7:4], y[3:0]}; feeds datapath currLoc.
- dir  out  2  direction to datapath: 00 y-1, 01 x+1, 10 x-1, 11 y+1; opposite(d) = ~d.
- rgLd  out  1  datapath register load, asserted on every location update.
- nxtLoc  in  8  datapath candidate location for currLoc/dir.
- cntReach  in  1  datapath boundary flag: move would leave the grid.
- memAdr  out  8  maze memory address.
- memRd  out  1  read strobe; data valid next cycle.
- memRdData  in  1  1 = wall or visited, 0 = free.
- memWr  out  1  write strobe; writes 1 (visited) at memAdr.
- push  out  1  push stkDin.
- pop  out  1  pop top entry.
- stkDin  out  2  direction pushed.
- stkTop  in  2  combinational top of stack.
- stkEmpty  in  1  stack empty.
- done  out  1  goal reached; held until start or rst.
- fail  out  1  no path exists; held until start or rst.

Behaviour:
- Reset: state=IDLE; currLoc=START_LOC; dirReg=00; all strobes, done and fail = 0. Reset mid-search aborts immediately; stack and memory contents are not cleared by this block.
- dir output = dirReg in all states except BACK, where it is ~stkTop.
- States and transitions (one state per cycle):
  - IDLE: start -> INIT.
  - INIT: currLoc<=START_LOC; dirReg<=00; memWr=1 with memAdr=START_LOC; rgLd=1; done=fail=0 -> CHECK.
  - CHECK: currLoc==GOAL_LOC -> DONE, else -> TRY.
  - TRY: cntReach=1 -> NEXT. Otherwise memRd=1, memAdr=nxtLoc -> READ.
  - READ: memRdData=1 -> NEXT, else -> MOVE. memAdr is held at nxtLoc.
  - MOVE: push=1, stkDin=dirReg; memWr=1, memAdr=nxtLoc; currLoc<=nxtLoc; rgLd=1; dirReg<=00 -> CHECK.
  - NEXT: dirReg==11 -> POPCHK, else dirReg<=dirReg+1 -> TRY.
  - POPCHK: stkEmpty -> FAIL, else -> BACK.
  - BACK: dir=~stkTop; pop=1; currLoc<=nxtLoc; rgLd=1; dirReg<=stkTop -> NEXT. The return move is never bounds-checked, since it reverses a valid move.
  - DONE: done=1. start -> INIT.
  - FAIL: fail=1. start -> INIT.
- start is ignored in all other states.
- Forward step latency: TRY->READ->MOVE->CHECK, 4 cycles per successful move including CHECK.
- Boundary conditions:
  - When START_LOC==GOAL_LOC, done asserts 3 cycles after start is sampled (INIT, CHECK, DONE).
  - When push and stack-full coincide, the condition is the stack's responsibility; this block has no overflow flag.
  - Directions are retried in fixed order 00,01,10,11.
  - memAdr=currLoc whenever the state drives no address.

Decomposition:
- Shared package maze_pkg: state enum; direction constants DIR_UP=00, DIR_RIGHT=01, DIR_LEFT=10, DIR_DOWN=11; function opposite(d)=~d.
- The direction stack is a separate sub-module, dir_stack (depth 256 x 2 bits, stkTop combinational); it is not inside this block.
- The controller itself is a single module.

Test Plan:
- Reset during MOVE -> next cycle: IDLE, currLoc=8'h00, done=fail=push=0.
- All cells walls except (0,0), then start -> 4 direction tries, 0 pushes, POPCHK sees stkEmpty, fail=1, done=0, currLoc=8'h00.
- Row y=0 and column x=15 free, all else walls -> exactly 30 pushes, 0 pops, done=1, currLoc=8'hFF, fail=0.
- Free cells (0,0),(1,0) only -> 1 push (dir 01), 1 pop with dir=10 in BACK, currLoc returns to 8'h00, fail=1.
- GOAL_LOC=START_LOC=8'h00 -> done=1 exactly 3 cycles after start sampled, no memRd issued.
- After DONE, pulse start with maze memory re-initialised -> INIT re-entered, done drops to 0 next cycle, search repeats with identical push count.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the rat-in-maze controller: FSM state codes,
// move directions and the direction-reversal helper.
package maze_pkg;

    typedef logic [1:0] dir_t;
    typedef logic [3:0] state_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_DOWN  = 2'b11;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_INIT   = 4'd1;
    localparam state_t ST_CHECK  = 4'd2;
    localparam state_t ST_TRY    = 4'd3;
    localparam state_t ST_READ   = 4'd4;
    localparam state_t ST_MOVE   = 4'd5;
    localparam state_t ST_NEXT   = 4'd6;
    localparam state_t ST_POPCHK = 4'd7;
    localparam state_t ST_BACK   = 4'd8;
    localparam state_t ST_DONE   = 4'd9;
    localparam state_t ST_FAIL   = 4'd10;

    // The encoding pairs each direction with its reverse as bitwise complements.
    function automatic dir_t opposite(input dir_t d);
        return ~d;
    endfunction

endpackage

// File: rtl/maze_controller_if.sv
// Bundle of the controller's links to the location datapath, maze memory
// and direction stack; master is the controller, slave the surrounding logic.
interface maze_if;
    import maze_pkg::*;

    logic       start;
    logic [7:0] currLoc;
    dir_t       dir;
    logic       rgLd;
    logic [7:0] nxtLoc;
    logic       cntReach;
    logic [7:0] memAdr;
    logic       memRd;
    logic       memRdData;
    logic       memWr;
    logic       push;
    logic       pop;
    dir_t       stkDin;
    dir_t       stkTop;
    logic       stkEmpty;
    logic       done;
    logic       fail;

    modport master (
        input  start, nxtLoc, cntReach, memRdData, stkTop, stkEmpty,
        output currLoc, dir, rgLd, memAdr, memRd, memWr, push, pop, stkDin,
               done, fail
    );

    modport slave (
        output start, nxtLoc, cntReach, memRdData, stkTop, stkEmpty,
        input  currLoc, dir, rgLd, memAdr, memRd, memWr, push, pop, stkDin,
               done, fail
    );

endinterface

// File: rtl/maze_controller.sv
// Depth-first search sequencer for a 16x16 maze: tries directions in fixed
// order, marks visited cells, and backtracks through the external direction stack.
module maze_controller
    import maze_pkg::*;
#(
    parameter logic [7:0] START_LOC = 8'h00,
    parameter logic [7:0] GOAL_LOC  = 8'hFF
) (
    input  logic clk,
    input  logic rst,
    maze_if.master bus
);

    state_t     state_q, state_d;
    logic [7:0] curr_loc_q, curr_loc_d;
    dir_t       dir_reg_q, dir_reg_d;

    dir_t       dir_o;
    logic       rg_ld;
    logic [7:0] mem_adr;
    logic       mem_rd;
    logic       mem_wr;
    logic       push_o;
    logic       pop_o;
    logic       done_o;
    logic       fail_o;

    always_comb begin
        state_d    = state_q;
        curr_loc_d = curr_loc_q;
        dir_reg_d  = dir_reg_q;
        dir_o      = dir_reg_q;
        rg_ld      = 1'b0;
        mem_adr    = curr_loc_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        push_o     = 1'b0;
        pop_o      = 1'b0;
        done_o     = 1'b0;
        fail_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_INIT;
            end
            ST_INIT: begin
                curr_loc_d = START_LOC;
                dir_reg_d  = DIR_UP;
                mem_wr     = 1'b1;
                mem_adr    = START_LOC;
                rg_ld      = 1'b1;
                state_d    = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = (curr_loc_q == GOAL_LOC) ? ST_DONE : ST_TRY;
            end
            ST_TRY: begin
                if (bus.cntReach) begin
                    state_d = ST_NEXT;
                end else begin
                    mem_rd  = 1'b1;
                    mem_adr = bus.nxtLoc;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Address stays on the candidate while the memory returns its bit.
                mem_adr = bus.nxtLoc;
                state_d = bus.memRdData ? ST_NEXT : ST_MOVE;
            end
            ST_MOVE: begin
                push_o     = 1'b1;
                mem_wr     = 1'b1;
                mem_adr    = bus.nxtLoc;
                curr_loc_d = bus.nxtLoc;
                rg_ld      = 1'b1;
                dir_reg_d  = DIR_UP;
                state_d    = ST_CHECK;
            end
            ST_NEXT: begin
                if (dir_reg_q == DIR_DOWN) begin
                    state_d = ST_POPCHK;
                end else begin
                    dir_reg_d = dir_reg_q + 2'd1;
                    state_d   = ST_TRY;
                end
            end
            ST_POPCHK: begin
                state_d = bus.stkEmpty ? ST_FAIL : ST_BACK;
            end
            ST_BACK: begin
                // Undo the last forward move; resume with the direction after it.
                dir_o      = opposite(bus.stkTop);
                pop_o      = 1'b1;
                curr_loc_d = bus.nxtLoc;
                rg_ld      = 1'b1;
                dir_reg_d  = bus.stkTop;
                state_d    = ST_NEXT;
            end
            ST_DONE: begin
                done_o = 1'b1;
                if (bus.start) state_d = ST_INIT;
            end
            ST_FAIL: begin
                fail_o = 1'b1;
                if (bus.start) state_d = ST_INIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            curr_loc_q <= START_LOC;
            dir_reg_q  <= DIR_UP;
        end else begin
            state_q    <= state_d;
            curr_loc_q <= curr_loc_d;
            dir_reg_q  <= dir_reg_d;
        end
    end

    assign bus.currLoc = curr_loc_q;
    assign bus.dir     = dir_o;
    assign bus.rgLd    = rg_ld;
    assign bus.memAdr  = mem_adr;
    assign bus.memRd   = mem_rd;
    assign bus.memWr   = mem_wr;
    assign bus.push    = push_o;
    assign bus.pop     = pop_o;
    assign bus.stkDin  = dir_reg_q;
    assign bus.done    = done_o;
    assign bus.fail    = fail_o;

endmodule
